// File: rtl/dpram_rd_stream_pkg.sv
// Shared types and sizing helpers for the DPRAM read-burst streamer.
package dpram_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Reads in flight plus one registered head word plus one word of slack.
  function automatic int skid_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO. The head word is served from registered storage and
// forced to zero while the FIFO is empty.
module stream_skid_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/dpram_rd_stream.sv
// Streams a burst of words out of an external RAM read port with a skid FIFO
// sized so the sink can stall at any point without losing data.
//
// state | meaning
// IDLE  | waiting for a command; zero-length commands complete here
// ISSUE | issuing one read per cycle while the skid FIFO has room reserved
// DRAIN | all reads issued; waiting for the last word to leave
module dpram_rd_stream
  import dpram_rd_stream_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAX_SIZE = 256,
  parameter int RD_LAT   = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW-1:0] cmd_len_i,
  output logic [AW-1:0] ram_raddr_o,
  input  logic [DW-1:0] ram_dout_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int SKID = skid_depth(RD_LAT);
  localparam int CW   = $clog2(SKID + 1);
  localparam int OW   = CW + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, len_q, len_d, raddr_q, addr_nxt;
  logic          done_q, done_d;
  logic          issue, issue_last, can_issue, pop;
  logic          cap_v, cap_last, inflight;
  logic [CW-1:0] fifo_cnt;
  logic [DW:0]   head;

  assign addr_nxt  = (addr_q == AW'(MAX_SIZE - 1)) ? '0 : addr_q + AW'(1);
  // Space is reserved at issue time, so a capture always finds a free slot.
  assign can_issue = (({1'b0, fifo_cnt} + OW'(inflight)) < OW'(SKID));
  assign pop       = out_valid_o && out_ready_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_addr_i;
            len_d   = cmd_len_i;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (can_issue) begin
          issue      = 1'b1;
          issue_last = (len_q == AW'(1));
          addr_d     = addr_nxt;
          len_d      = len_q - AW'(1);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last_o) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      raddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      if (issue) raddr_q <= addr_q;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_tag_bypass
      assign cap_v    = issue;
      assign cap_last = issue_last;
      assign inflight = 1'b0;
    end else begin : g_tag_pipe
      logic tag_v_q, tag_last_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          tag_v_q    <= 1'b0;
          tag_last_q <= 1'b0;
        end else begin
          tag_v_q    <= issue;
          tag_last_q <= issue_last;
        end
      end
      assign cap_v    = tag_v_q;
      assign cap_last = tag_last_q;
      assign inflight = tag_v_q;
    end
  endgenerate

  stream_skid_fifo #(
    .DEPTH (SKID),
    .W     (DW + 1)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (cap_v),
    .push_data_i ({cap_last, ram_dout_i}),
    .pop_i       (pop),
    .valid_o     (out_valid_o),
    .data_o      (head),
    .count_o     (fifo_cnt)
  );

  assign ram_raddr_o = issue ? addr_q : raddr_q;
  assign out_last_o  = head[DW];
  assign out_data_o  = head[DW-1:0];
  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_dpram_rd_stream.sv
// Directed bench driving a RD_LAT=0 and a RD_LAT=1 streamer side by side.
module tb_dpram_rd_stream;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, out_ready;
  logic [15:0] cmd_addr, cmd_len;
  logic [15:0] raddr [2];
  logic [7:0]  odata [2];
  logic        cready [2], ovalid [2], olast [2], busy [2], done [2];
  logic [7:0]  dout0, dout1;
  logic [3:0]  fcnt [2];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  function automatic int wr(input int a);
    return a % 256;
  endfunction

  assign dout0 = ram_val(int'(raddr[0]));
  always @(posedge clk) dout1 <= ram_val(int'(raddr[1]));

  dpram_rd_stream #(.AW(16), .DW(8), .MAX_SIZE(256), .RD_LAT(0)) u_lat0 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cready[0]),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .ram_raddr_o(raddr[0]),
    .ram_dout_i(dout0), .out_valid_o(ovalid[0]), .out_ready_i(out_ready),
    .out_data_o(odata[0]), .out_last_o(olast[0]), .busy_o(busy[0]), .done_o(done[0]));

  dpram_rd_stream #(.AW(16), .DW(8), .MAX_SIZE(256), .RD_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cready[1]),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .ram_raddr_o(raddr[1]),
    .ram_dout_i(dout1), .out_valid_o(ovalid[1]), .out_ready_i(out_ready),
    .out_data_o(odata[1]), .out_last_o(olast[1]), .busy_o(busy[1]), .done_o(done[1]));

  assign fcnt[0] = 4'(u_lat0.u_fifo.count_o);
  assign fcnt[1] = 4'(u_lat1.u_fifo.count_o);

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s [lat%0d]: observed %0d expected %0d", tag, d, obs, exp);
    end
  endtask

  // Issues one command to both DUTs and scoreboards the resulting streams.
  task automatic run_burst(input int addr, input int len, input bit rnd);
    int idx [2], first [2], dcnt [2], lastx [2], bub [2], maxc [2];
    int cyc, tail;
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; first[d] = -1; dcnt[d] = 0; lastx[d] = -10; bub[d] = 0; maxc[d] = 0;
      chk("cmd_ready_pre", d, cready[d], 1);
    end
    cmd_valid = 1'b1; cmd_addr = 16'(addr); cmd_len = 16'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1; tail = 0;
    while (cyc < 400 && tail < 3) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (!rnd && len > 0 && cyc <= len) chk("raddr_seq", d, raddr[d], wr(addr + cyc - 1));
        if (cyc == 1 && len > 0) chk("busy_after_accept", d, busy[d], 1);
        if (int'(fcnt[d]) > maxc[d]) maxc[d] = int'(fcnt[d]);
        if (done[d]) begin
          dcnt[d]++;
          chk("done_timing", d, cyc, (len == 0) ? 1 : lastx[d] + 1);
        end
        if (ovalid[d]) begin
          if (first[d] < 0) first[d] = cyc;
          chk("no_extra_word", d, idx[d] < len, 1);
          chk("data", d, odata[d], ram_val(wr(addr + idx[d])));
          chk("last", d, olast[d], idx[d] == len - 1);
          if (out_ready) begin
            idx[d]++;
            lastx[d] = cyc;
          end
        end else if (first[d] >= 0 && idx[d] < len) begin
          bub[d]++;
        end
      end
      if (dcnt[0] > 0 && dcnt[1] > 0) tail++;
      @(negedge clk);
      cyc++;
    end
    chk("burst_timeout", 0, tail >= 3, 1);
    for (int d = 0; d < 2; d++) begin
      chk("word_count", d, idx[d], len);
      chk("done_count", d, dcnt[d], 1);
      if (len > 0) chk("first_latency", d, first[d], 2 + d);
      if (!rnd) chk("bubbles", d, bub[d], 0);
      chk("fifo_bound", d, maxc[d] <= d + 2, 1);
      chk("idle_after", d, busy[d], 0);
    end
  endtask

  initial begin
    int n, ndone [2];
    logic [15:0] r0, r1;
    logic pdone [2];
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, ovalid[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_done", d, done[d], 0);
      chk("rst_cmd_ready", d, cready[d], 0);
      chk("rst_raddr", d, raddr[d], 0);
      chk("rst_out_data", d, odata[d], 0);
      chk("rst_out_last", d, olast[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk("cmd_ready_post_rst", d, cready[d], 1);
    @(negedge clk);

    run_burst(10, 4, 1'b0);
    run_burst(254, 4, 1'b0);

    r0 = raddr[0]; r1 = raddr[1];
    run_burst(5, 0, 1'b0);
    chk("len0_raddr_hold", 0, raddr[0], r0);
    chk("len0_raddr_hold", 1, raddr[1], r1);

    run_burst(100, 16, 1'b1);
    run_burst(250, 16, 1'b1);

    // Reset after the third word of an 8-word burst.
    out_ready = 1'b1; cmd_addr = 16'd20; cmd_len = 16'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      if (ovalid[1] && out_ready) n++;
      @(negedge clk);
    end
    chk("rst_mid_reached", 1, n, 3);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_valid", d, ovalid[d], 0);
      chk("rst_mid_busy", d, busy[d], 0);
      chk("rst_mid_done", d, done[d], 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_mid_no_done", d, done[d], 0);
        chk("rst_mid_no_valid", d, ovalid[d], 0);
      end
    end
    run_burst(0, 2, 1'b0);

    // Command held valid: re-accept in every done cycle.
    out_ready = 1'b1; cmd_addr = 16'd40; cmd_len = 16'd3; cmd_valid = 1'b1;
    for (int d = 0; d < 2; d++) begin ndone[d] = 0; pdone[d] = 1'b0; end
    for (int c = 0; c < 40; c++) begin
      for (int d = 0; d < 2; d++) begin
        chk("ready_vs_busy", d, cready[d], !busy[d]);
        if (pdone[d]) chk("reaccept", d, busy[d], 1);
        if (done[d]) begin
          ndone[d]++;
          chk("ready_at_done", d, cready[d], 1);
        end
        pdone[d] = done[d];
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 50 && (busy[0] || busy[1]); c++) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("b2b_drained", d, busy[d], 0);
      chk("b2b_bursts", d, ndone[d] >= 5, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_rd_stream.md
DPRAM_RD_STREAM -- requirements
Module: dpram_rd_stream

Interface
REQ-001 Parameter AW, default 16, address width of the RAM read port.
REQ-002 Parameter DW, default 8, data width.
REQ-003 Parameter MAX_SIZE, default 256, RAM depth in words; addresses wrap at MAX_SIZE-1 -> 0.
REQ-004 Parameter RD_LAT, default 1, RAM read latency in cycles; legal values 0 and 1 only.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  burst request valid.
REQ-008 cmd_ready  output  1  block can accept a burst.
REQ-009 cmd_addr  input  AW  start word address, must be < MAX_SIZE.
REQ-010 cmd_len  input  AW  burst length in words; 0 is legal.
REQ-011 ram_raddr  output  AW  RAM read address.
REQ-012 ram_dout  input  DW  RAM read data, valid RD_LAT cycles after ram_raddr.
REQ-013 out_valid  output  1  stream data valid.
REQ-014 out_ready  input  1  stream sink accepts data.
REQ-015 out_data  output  DW  stream data word.
REQ-016 out_last  output  1  final word of the burst, qualified by out_valid.
REQ-017 busy  output  1  burst in progress (state != IDLE).
REQ-018 done  output  1  one-cycle pulse when a burst completes.

Function
REQ-019 FSM states IDLE, ISSUE, DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-020 IDLE, cmd_valid&&cmd_ready, cmd_len=0: done pulses the next cycle, state stays IDLE, no RAM read and no out_valid.
REQ-021 IDLE, cmd_valid&&cmd_ready, cmd_len>0: latch address and length, go to ISSUE.
REQ-022 ISSUE: issue one read per cycle when (in-flight reads + words held in the skid FIFO) < SKID_DEPTH, with SKID_DEPTH = RD_LAT+2.
REQ-023 Each issued read drives ram_raddr with the current address; the next address is (addr==MAX_SIZE-1) ? 0 : addr+1.
REQ-024 ram_raddr SHALL hold its last value when no read is issued.
REQ-025 After the read for the final word is issued, go to DRAIN.
REQ-026 A per-read tag pipeline of RD_LAT stages (pass-through when RD_LAT=0) SHALL mark which cycle's ram_dout is captured into the skid FIFO, together with a last flag.
REQ-027 out_valid, out_data and out_last come from the registered skid-FIFO head; words transfer on out_valid&&out_ready.
REQ-028 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Latency: with the command accepted in cycle T and out_ready=1, the first read issues in T+1 and the first out_valid is in T+2+RD_LAT.
REQ-030 Throughput: with out_ready held at 1, one word per cycle with no bubbles after the first word.
REQ-031 Backpressure SHALL never drop or duplicate a word; the skid FIFO SHALL never overflow.
REQ-032 DRAIN: when the out_last word transfers, done pulses the next cycle and the state returns to IDLE.
REQ-033 Simultaneous events: a capture and a pop in the same cycle leave the FIFO count unchanged.

Reset
REQ-034 While rst=1: state=IDLE, FIFO and tag pipeline empty, ram_raddr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, cmd_ready=0.
REQ-035 cmd_ready=1 from the first cycle after rst deasserts.
REQ-036 Reset mid-burst: the burst is abandoned, out_valid=0 in the next cycle, no done pulse, in-flight RAM data discarded.

Structure
REQ-037 Package dpram_rd_stream_pkg SHALL hold the state enum typedef and the SKID_DEPTH computation function.
REQ-038 Sub-module stream_skid_fifo (synchronous, parameterised depth and width, count output) SHALL implement the skid buffer; the RAM itself is external (dpram).

Verification
REQ-039 RD_LAT=1, addr=10, len=4, out_ready=1: words RAM[10..13] in order, first out_valid at T+3, out_last on word 4, done pulse once.
REQ-040 MAX_SIZE=256, addr=254, len=4: ram_raddr sequence 254, 255, 0, 1.
REQ-041 len=0: done one cycle after accept, out_valid stays 0, ram_raddr unchanged.
REQ-042 RD_LAT=0 and RD_LAT=1, len=16, random out_ready (50%): 16 words in order, no loss or duplication, FIFO count never exceeds RD_LAT+2.
REQ-043 rst asserted after the 3rd word of len=8: next cycle out_valid=0, busy=0, no done; a new cmd addr=0, len=2 then returns RAM[0], RAM[1] correctly.
REQ-044 cmd_valid held high during a burst: cmd_ready=0 until the done cycle, and back-to-back bursts are accepted immediately after.
